// File: rtl/linear_layer_i4xi4_q_fifo_w8_d9_ctrl_pkg.sv
// Shared constants and helpers for the i4xi4 stream FIFO (8-bit, depth 9).
//   INT4X2_DATA_WIDTH : word width of a stream carrying two packed int4 values
//   DEFAULT_DEPTH     : total FIFO capacity (SRL entries + output register)
//   DEFAULT_ADDR_WIDTH: SRL address width
//   fifo_cnt_width()  : bits needed to hold an occupancy count 0..depth
package linear_layer_i4xi4_q_fifo_w8_d9_ctrl_pkg;

  localparam int INT4X2_DATA_WIDTH  = 8;
  localparam int DEFAULT_DEPTH      = 9;
  localparam int DEFAULT_ADDR_WIDTH = 4;

  function automatic int fifo_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/linear_layer_i4xi4_q_fifo_w8_d9_srl.sv
// Shift-register (SRL) storage for the stream FIFO.
//   clk  : clock
//   we   : shift din in at entry 0, every entry moves one place deeper
//   addr : read address, 0 = newest word
//   din  : write data
//   dout : combinational read of entry addr (0 when addr is out of range)
// Contents are deliberately not reset.
module linear_layer_i4xi4_q_fifo_w8_d9_srl
  import linear_layer_i4xi4_q_fifo_w8_d9_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = INT4X2_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH - 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  // Decoded mux keeps the index width independent of DEPTH.
  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_WIDTH'(i)) dout = mem[i];
    end
  end

endmodule

// File: rtl/linear_layer_i4xi4_q_fifo_w8_d9_ctrl.sv
// Control and first-word-fall-through output stage of the i4xi4 stream FIFO.
// Tracks SRL occupancy, generates SRL we/addr/din, and moves the oldest SRL
// word into an output register whenever that register is free or being read.
//   clk               : clock, all state on rising edge
//   reset_n           : asynchronous active-low reset
//   if_din/if_write   : write data / write request
//   if_full_n         : 1 = space available
//   if_dout           : head-of-FIFO data (output register)
//   if_read           : read request
//   if_empty_n        : 1 = if_dout valid
//   if_num_data_valid : total words held (SRL + output register)
//   if_fifo_cap       : constant DEPTH
module linear_layer_i4xi4_q_fifo_w8_d9_ctrl
  import linear_layer_i4xi4_q_fifo_w8_d9_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = INT4X2_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] if_din,
  input  logic                  if_write,
  output logic                  if_full_n,
  output logic [DATA_WIDTH-1:0] if_dout,
  input  logic                  if_read,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic [ADDR_WIDTH:0]   if_fifo_cap
);

  // Wide enough for the largest legal DEPTH (2^ADDR_WIDTH + 1).
  localparam int CNT_W = fifo_cnt_width((2 ** ADDR_WIDTH) + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [CNT_W-1:0]      srl_cnt;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;

  logic [CNT_W-1:0]      total;
  logic                  push;
  logic                  pop;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] srl_addr;
  logic [DATA_WIDTH-1:0] srl_dout;

  logic [CNT_W-1:0]      srl_cnt_nxt;
  logic                  out_valid_nxt;
  logic [DATA_WIDTH-1:0] out_data_nxt;

  // Full is decoded from registered state only, so neither if_read nor
  // if_write has a combinational path to if_full_n.
  assign total     = srl_cnt + {{(CNT_W-1){1'b0}}, out_valid};
  assign if_full_n = (total != DEPTH_C);

  assign push   = if_write & if_full_n;
  assign pop    = (srl_cnt != '0) & (~out_valid | if_read);
  assign accept = if_read & out_valid;

  // Address comes from registered srl_cnt, so the read of the oldest word
  // sees the SRL contents before this edge's shift.
  assign srl_addr = (srl_cnt != '0) ? ADDR_WIDTH'(srl_cnt - ONE_C) : '0;

  always_comb begin
    srl_cnt_nxt   = srl_cnt;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    if (push && !pop) srl_cnt_nxt = srl_cnt + ONE_C;
    if (pop && !push) srl_cnt_nxt = srl_cnt - ONE_C;
    out_valid_nxt = pop | (out_valid & ~accept);
    if (pop) out_data_nxt = srl_dout;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      srl_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      srl_cnt   <= srl_cnt_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
    end
  end

  assign if_empty_n        = out_valid;
  assign if_dout           = out_data;
  assign if_num_data_valid = (ADDR_WIDTH + 1)'(total);
  assign if_fifo_cap       = (ADDR_WIDTH + 1)'(DEPTH);

  linear_layer_i4xi4_q_fifo_w8_d9_srl #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH - 1)
  ) u_srl (
    .clk  (clk),
    .we   (push),
    .addr (srl_addr),
    .din  (if_din),
    .dout (srl_dout)
  );

endmodule

// File: tb/tb_linear_layer_i4xi4_q_fifo_w8_d9_ctrl.sv
module tb_linear_layer_i4xi4_q_fifo_w8_d9_ctrl;

  logic       clk;
  logic       reset_n;
  logic [7:0] if_din;
  logic       if_write;
  logic       if_full_n;
  logic [7:0] if_dout;
  logic       if_read;
  logic       if_empty_n;
  logic [4:0] if_num_data_valid;
  logic [4:0] if_fifo_cap;

  int n_assert = 0;
  int n_fail   = 0;

  linear_layer_i4xi4_q_fifo_w8_d9_ctrl dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .if_din            (if_din),
    .if_write          (if_write),
    .if_full_n         (if_full_n),
    .if_dout           (if_dout),
    .if_read           (if_read),
    .if_empty_n        (if_empty_n),
    .if_num_data_valid (if_num_data_valid),
    .if_fifo_cap       (if_fifo_cap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; outputs are sampled and inputs driven 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int exp_next;
    int got;
    reset_n  = 1'b0;
    if_din   = '0;
    if_write = 1'b0;
    if_read  = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    repeat (5) tick();

    // Reset / idle state
    chk("rst_empty_n", 32'(if_empty_n), 32'd0);
    chk("rst_full_n", 32'(if_full_n), 32'd1);
    chk("rst_count", 32'(if_num_data_valid), 32'd0);
    chk("rst_cap", 32'(if_fifo_cap), 32'd9);
    chk("rst_dout", 32'(if_dout), 32'h00);

    // Single write: visible at the output two edges later
    if_din = 8'hA5; if_write = 1'b1;
    tick();
    if_write = 1'b0;
    chk("w1_empty_n_after1", 32'(if_empty_n), 32'd0);
    chk("w1_count_after1", 32'(if_num_data_valid), 32'd1);
    tick();
    chk("w1_empty_n_after2", 32'(if_empty_n), 32'd1);
    chk("w1_dout", 32'(if_dout), 32'hA5);
    chk("w1_count_after2", 32'(if_num_data_valid), 32'd1);
    if_read = 1'b1;
    tick();
    if_read = 1'b0;
    chk("w1_drained_empty_n", 32'(if_empty_n), 32'd0);
    chk("w1_drained_count", 32'(if_num_data_valid), 32'd0);

    // Fill to capacity with 0x01..0x09
    for (int i = 1; i <= 9; i++) begin
      chk("fill_full_n_before", 32'(if_full_n), 32'd1);
      if_din = 8'(i); if_write = 1'b1;
      tick();
    end
    if_write = 1'b0;
    chk("fill_full_n", 32'(if_full_n), 32'd0);
    chk("fill_count", 32'(if_num_data_valid), 32'd9);
    chk("fill_dout", 32'(if_dout), 32'h01);

    // Write while full is ignored
    if_din = 8'hFF; if_write = 1'b1;
    tick();
    if_write = 1'b0;
    chk("ovf_count", 32'(if_num_data_valid), 32'd9);
    chk("ovf_full_n", 32'(if_full_n), 32'd0);
    chk("ovf_dout", 32'(if_dout), 32'h01);

    // One read from full: space reappears the next cycle
    if_read = 1'b1;
    tick();
    if_read = 1'b0;
    chk("rd1_full_n", 32'(if_full_n), 32'd1);
    chk("rd1_count", 32'(if_num_data_valid), 32'd8);
    chk("rd1_dout", 32'(if_dout), 32'h02);

    // Drain remaining 0x02..0x09; 0xFF must never appear
    if_read = 1'b1;
    for (int k = 2; k <= 9; k++) begin
      chk("drain_empty_n", 32'(if_empty_n), 32'd1);
      chk("drain_dout", 32'(if_dout), 32'(k));
      tick();
    end
    if_read = 1'b0;
    chk("drain_done_empty_n", 32'(if_empty_n), 32'd0);
    chk("drain_done_count", 32'(if_num_data_valid), 32'd0);

    // Streaming 0x10..0x3F with if_read held high
    exp_next = 16'h10;
    got = 0;
    if_read = 1'b1;
    for (int c = 0; c < 70; c++) begin
      if (c < 48) begin
        if_din = 8'(16'h10 + c); if_write = 1'b1;
      end else begin
        if_write = 1'b0;
      end
      tick();
      if (c == 0) chk("stream_fill_empty_n_c0", 32'(if_empty_n), 32'd0);
      if (c == 1) chk("stream_fill_empty_n_c1", 32'(if_empty_n), 32'd1);
      if (c >= 1 && c <= 48) chk("stream_steady_valid", 32'(if_empty_n), 32'd1);
      chk("stream_full_n", 32'(if_full_n), 32'd1);
      chk("stream_count_le2", 32'(if_num_data_valid <= 5'd2), 32'd1);
      if (if_empty_n) begin
        chk("stream_dout", 32'(if_dout), 32'(exp_next));
        exp_next++;
        got++;
      end
    end
    if_read = 1'b0;
    chk("stream_words", 32'(got), 32'd48);
    chk("stream_end_empty_n", 32'(if_empty_n), 32'd0);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) begin
      if_din = 8'(16'h50 + i); if_write = 1'b1;
      tick();
    end
    if_din = 8'h60;
    chk("prerst_count", 32'(if_num_data_valid), 32'd5);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_empty_n", 32'(if_empty_n), 32'd0);
    chk("arst_full_n", 32'(if_full_n), 32'd1);
    chk("arst_count", 32'(if_num_data_valid), 32'd0);
    chk("arst_dout", 32'(if_dout), 32'h00);
    if_write = 1'b0;
    #1 reset_n = 1'b1;
    tick();
    chk("postrst_count", 32'(if_num_data_valid), 32'd0);
    if_din = 8'h77; if_write = 1'b1;
    tick();
    if_write = 1'b0;
    chk("w77_empty_n_after1", 32'(if_empty_n), 32'd0);
    tick();
    chk("w77_empty_n_after2", 32'(if_empty_n), 32'd1);
    chk("w77_dout", 32'(if_dout), 32'h77);
    chk("w77_count", 32'(if_num_data_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
